// File: rtl/dma_writer_eof.sv
`default_nettype none
// ============================================================================
// Module      : dma_writer_eof
// Description : Stream-to-memory writer over an AXI3 write master. A transfer
//               ends on the EOF word or after the configured length.
// Revision    : 1.0
// ============================================================================
module dma_writer_eof #(
  parameter int DATA_BITS   = 64,
  parameter int ADDR_BITS   = 32,
  parameter int LENGTH_BITS = 16,
  parameter int BURST_SIZE  = 16,
  parameter int FIFO_DEPTH  = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ADDR_BITS-1:0]   cfg_addr,
  input  logic [LENGTH_BITS-1:0] cfg_len,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [DATA_BITS-1:0]   din_data,
  input  logic                   din_eof,
  output logic                   mst_awvalid,
  input  logic                   mst_awready,
  output logic [ADDR_BITS-1:0]   mst_awaddr,
  output logic [3:0]             mst_awlen,
  output logic [3:0]             mst_awid,
  output logic [2:0]             mst_awsize,
  output logic [1:0]             mst_awburst,
  output logic [1:0]             mst_awlock,
  output logic                   mst_wvalid,
  input  logic                   mst_wready,
  output logic [DATA_BITS-1:0]   mst_wdata,
  output logic [DATA_BITS/8-1:0] mst_wstrb,
  output logic                   mst_wlast,
  output logic [3:0]             mst_wid,
  input  logic                   mst_bvalid,
  output logic                   mst_bready,
  input  logic [3:0]             mst_bid,
  input  logic [1:0]             mst_bresp,
  output logic                   done,
  output logic [LENGTH_BITS-1:0] xfer_words,
  output logic                   xfer_eof,
  output logic [1:0]             error
);

  localparam int BPW       = DATA_BITS / 8;
  localparam int SIZE_LOG2 = $clog2(BPW);
  localparam int FIFO_AW   = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = FIFO_AW + 1;
  localparam int BW        = 5;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PREP      = 2'd1,
    S_ISSUE     = 2'd2,
    S_WAIT_RESP = 2'd3
  } state_t;

  state_t                 r_state, w_state_next;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [LENGTH_BITS-1:0] r_len, r_accepted, r_issued, r_outstanding;
  logic                   r_closed, r_closed_eof;

  logic [DATA_BITS-1:0]   r_fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]       r_fifo_count;

  logic [BW-1:0]          r_bq [4];
  logic [1:0]             r_bq_wr, r_bq_rd;
  logic [2:0]             r_bq_count;

  logic                   r_w_active;
  logic [BW-1:0]          r_beats_left;
  logic                   r_awvalid;
  logic [ADDR_BITS-1:0]   r_awaddr;
  logic [3:0]             r_awlen;
  logic                   r_done, r_xfer_eof;
  logic [LENGTH_BITS-1:0] r_xfer_words;
  logic [1:0]             r_error;

  logic                   w_din_fire, w_w_fire, w_w_last_beat, w_bq_pop, w_b_dec;
  logic                   w_issue_cond, w_issue, w_finish, w_cfg_take;
  logic [LENGTH_BITS-1:0] w_unissued;
  logic [12:0]            w_until_4k, w_thresh;
  logic [31:0]            w_unissued_ext, w_thresh_ext, w_cand_wide;
  logic [BW-1:0]          w_cand;
  logic                   w_unused_ok;

  assign w_din_fire = din_valid && din_ready;
  assign din_ready  = (r_state != S_IDLE) && !r_closed && (r_fifo_count != CNT_W'(FIFO_DEPTH));
  assign cfg_ready  = (r_state == S_IDLE);

  // Burst size is capped by the AXI limit and by the distance to the next 4 KB page.
  assign w_unissued     = r_accepted - r_issued;
  assign w_until_4k     = (13'h1000 - {1'b0, r_addr[11:0]}) >> SIZE_LOG2;
  assign w_thresh       = (w_until_4k < 13'(BURST_SIZE)) ? w_until_4k : 13'(BURST_SIZE);
  assign w_unissued_ext = 32'(w_unissued);
  assign w_thresh_ext   = 32'(w_thresh);
  assign w_cand_wide    = (w_unissued_ext < w_thresh_ext) ? w_unissued_ext : w_thresh_ext;
  assign w_cand         = w_cand_wide[BW-1:0];

  assign w_issue_cond = !r_awvalid && (r_bq_count != 3'd4) &&
                        ((w_unissued_ext >= w_thresh_ext) || (r_closed && (w_unissued != '0)));

  assign w_w_fire      = r_w_active && mst_wready;
  assign w_w_last_beat = (r_beats_left == BW'(1));
  assign w_bq_pop      = (r_bq_count != 3'd0) && (!r_w_active || (w_w_fire && w_w_last_beat));
  assign w_b_dec       = mst_bvalid && (r_outstanding != '0);

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_finish     = 1'b0;
    w_cfg_take   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_valid) begin
          w_cfg_take = 1'b1;
          if (cfg_len != '0) w_state_next = S_PREP;
        end
      end
      S_PREP: w_state_next = S_ISSUE;
      S_ISSUE: begin
        if (w_issue_cond) begin
          w_issue      = 1'b1;
          w_state_next = S_PREP;
        end else if (r_closed && (w_unissued == '0) && !r_awvalid) begin
          w_state_next = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if ((r_outstanding == '0) && !r_w_active && (r_bq_count == 3'd0)) begin
          w_finish     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_accepted    <= '0;
      r_issued      <= '0;
      r_closed      <= 1'b0;
      r_closed_eof  <= 1'b0;
      r_outstanding <= '0;
      r_done        <= 1'b0;
      r_xfer_words  <= '0;
      r_xfer_eof    <= 1'b0;
      r_error       <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_finish;
      if (w_cfg_take && (cfg_len != '0)) begin
        r_addr       <= cfg_addr;
        r_len        <= cfg_len;
        r_accepted   <= '0;
        r_issued     <= '0;
        r_closed     <= 1'b0;
        r_closed_eof <= 1'b0;
      end
      if (w_din_fire) begin
        r_accepted <= r_accepted + LENGTH_BITS'(1);
        if (din_eof) begin
          r_closed     <= 1'b1;
          r_closed_eof <= 1'b1;
        end
        if ((r_accepted + LENGTH_BITS'(1)) == r_len) r_closed <= 1'b1;
      end
      if (w_issue) begin
        r_issued <= r_issued + LENGTH_BITS'(w_cand);
        r_addr   <= r_addr + (ADDR_BITS'(w_cand) << SIZE_LOG2);
      end
      // A response and a new issue in the same cycle cancel out.
      case ({w_issue, w_b_dec})
        2'b10:   r_outstanding <= r_outstanding + LENGTH_BITS'(1);
        2'b01:   r_outstanding <= r_outstanding - LENGTH_BITS'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (mst_bvalid && (mst_bresp != 2'b00)) r_error <= mst_bresp;
      if (w_finish) begin
        r_xfer_words <= r_accepted;
        r_xfer_eof   <= r_closed_eof;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_din_fire) r_fifo_mem[r_wr_ptr] <= din_data;
    if (w_issue)    r_bq[r_bq_wr]        <= w_cand;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_din_fire)
        r_wr_ptr <= (r_wr_ptr == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + FIFO_AW'(1);
      if (w_w_fire)
        r_rd_ptr <= (r_rd_ptr == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + FIFO_AW'(1);
      case ({w_din_fire, w_w_fire})
        2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // W side runs on its own, fed by the burst-length queue; the FIFO always
  // holds the data of every queued burst, so beats never stall on the source.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bq_wr      <= '0;
      r_bq_rd      <= '0;
      r_bq_count   <= '0;
      r_w_active   <= 1'b0;
      r_beats_left <= '0;
      r_awvalid    <= 1'b0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
    end else begin
      if (w_issue) r_bq_wr <= r_bq_wr + 2'd1;
      if (w_bq_pop) r_bq_rd <= r_bq_rd + 2'd1;
      case ({w_issue, w_bq_pop})
        2'b10:   r_bq_count <= r_bq_count + 3'd1;
        2'b01:   r_bq_count <= r_bq_count - 3'd1;
        default: r_bq_count <= r_bq_count;
      endcase
      if (w_bq_pop) begin
        r_w_active   <= 1'b1;
        r_beats_left <= r_bq[r_bq_rd];
      end else if (w_w_fire) begin
        if (w_w_last_beat) r_w_active <= 1'b0;
        else               r_beats_left <= r_beats_left - BW'(1);
      end
      if (w_issue) begin
        r_awvalid <= 1'b1;
        r_awaddr  <= r_addr;
        r_awlen   <= 4'(w_cand - BW'(1));
      end else if (r_awvalid && mst_awready) begin
        r_awvalid <= 1'b0;
      end
    end
  end

  assign mst_awvalid = r_awvalid;
  assign mst_awaddr  = r_awaddr;
  assign mst_awlen   = r_awlen;
  assign mst_awid    = 4'd0;
  assign mst_awsize  = 3'(SIZE_LOG2);
  assign mst_awburst = 2'b01;
  assign mst_awlock  = 2'b00;
  assign mst_wvalid  = r_w_active;
  assign mst_wdata   = r_fifo_mem[r_rd_ptr];
  assign mst_wstrb   = '1;
  assign mst_wlast   = r_w_active && w_w_last_beat;
  assign mst_wid     = 4'd0;
  assign mst_bready  = 1'b1;
  assign done        = r_done;
  assign xfer_words  = r_xfer_words;
  assign xfer_eof    = r_xfer_eof;
  assign error       = r_error;

  assign w_unused_ok = ^{mst_bid, w_cand_wide[31:BW]};

endmodule
`default_nettype wire

// File: tb/tb_dma_writer_eof.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_writer_eof
// Description : Scoreboard bench for dma_writer_eof with a randomised AXI slave.
// Revision    : 1.0
// ============================================================================
module tb_dma_writer_eof;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_addr;
  logic [15:0] cfg_len;
  logic        din_valid, din_ready, din_eof;
  logic [63:0] din_data;
  logic        mst_awvalid, mst_awready;
  logic [31:0] mst_awaddr;
  logic [3:0]  mst_awlen, mst_awid;
  logic [2:0]  mst_awsize;
  logic [1:0]  mst_awburst, mst_awlock;
  logic        mst_wvalid, mst_wready, mst_wlast;
  logic [63:0] mst_wdata;
  logic [7:0]  mst_wstrb;
  logic [3:0]  mst_wid;
  logic        mst_bvalid, mst_bready;
  logic [3:0]  mst_bid;
  logic [1:0]  mst_bresp;
  logic        done, xfer_eof;
  logic [15:0] xfer_words;
  logic [1:0]  error;

  always #5 clk = ~clk;

  dma_writer_eof dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_eof(din_eof),
    .mst_awvalid(mst_awvalid), .mst_awready(mst_awready), .mst_awaddr(mst_awaddr),
    .mst_awlen(mst_awlen), .mst_awid(mst_awid), .mst_awsize(mst_awsize),
    .mst_awburst(mst_awburst), .mst_awlock(mst_awlock),
    .mst_wvalid(mst_wvalid), .mst_wready(mst_wready), .mst_wdata(mst_wdata),
    .mst_wstrb(mst_wstrb), .mst_wlast(mst_wlast), .mst_wid(mst_wid),
    .mst_bvalid(mst_bvalid), .mst_bready(mst_bready), .mst_bid(mst_bid), .mst_bresp(mst_bresp),
    .done(done), .xfer_words(xfer_words), .xfer_eof(xfer_eof), .error(error)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] exp_aw_addr[$];
  logic [3:0]  exp_aw_len[$];
  int          exp_w_blen[$];
  logic [63:0] exp_wdata[$];
  int          b_times[$];

  bit aw_rand = 0, w_rand = 0;
  int b_delay = 1;
  int slverr_burst = -1;
  int aw_hs_cnt = 0, wl_cnt = 0, b_sched_cnt = 0, b_hs_cnt = 0;
  int w_beat = 0, cur_blen = 1, done_cnt = 0;
  logic [31:0] sb_a;
  logic [3:0]  sb_l;
  logic [63:0] sb_d;

  always @(posedge clk) cyc <= cyc + 1;

  // AXI slave model and output scoreboard; decisions made here take effect at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      mst_awready = 1'b0;
      mst_wready  = 1'b0;
      mst_bvalid  = 1'b0;
      mst_bresp   = 2'b00;
    end else begin
      mst_awready = aw_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      mst_wready  = w_rand  ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (done) done_cnt++;
      if (mst_awvalid && mst_awready) begin
        checks++;
        if (exp_aw_addr.size() == 0) begin
          errors++;
          $display("FAIL aw_unexpected addr=%h len=%0d", mst_awaddr, mst_awlen);
        end else begin
          sb_a = exp_aw_addr.pop_front();
          sb_l = exp_aw_len.pop_front();
          if (mst_awaddr !== sb_a || mst_awlen !== sb_l) begin
            errors++;
            $display("FAIL aw_burst got addr=%h len=%0d want addr=%h len=%0d",
                     mst_awaddr, mst_awlen, sb_a, sb_l);
          end
        end
        aw_hs_cnt++;
      end
      if (w_beat > 0) begin
        checks++;
        if (mst_wvalid !== 1'b1) begin
          errors++;
          $display("FAIL w_stall got wvalid=%b want 1 at beat %0d", mst_wvalid, w_beat);
        end
      end
      if (mst_wvalid && mst_wready) begin
        if (w_beat == 0) begin
          checks++;
          if (exp_w_blen.size() == 0) begin
            errors++;
            $display("FAIL w_unexpected_burst data=%h", mst_wdata);
            cur_blen = 1;
          end else begin
            cur_blen = exp_w_blen.pop_front();
          end
        end
        checks++;
        if (exp_wdata.size() == 0) begin
          errors++;
          $display("FAIL w_unexpected_data got %h", mst_wdata);
        end else begin
          sb_d = exp_wdata.pop_front();
          if (mst_wdata !== sb_d) begin
            errors++;
            $display("FAIL w_data got %h want %h", mst_wdata, sb_d);
          end
        end
        checks++;
        if (mst_wlast !== (w_beat == cur_blen - 1)) begin
          errors++;
          $display("FAIL w_last got %b want %b (beat %0d of %0d)",
                   mst_wlast, (w_beat == cur_blen - 1), w_beat, cur_blen);
        end
        if (w_beat == cur_blen - 1) begin
          w_beat = 0;
          wl_cnt++;
        end else begin
          w_beat++;
        end
      end
      while (b_sched_cnt < ((aw_hs_cnt < wl_cnt) ? aw_hs_cnt : wl_cnt)) begin
        b_times.push_back(cyc + b_delay);
        b_sched_cnt++;
      end
      if (b_times.size() > 0 && b_times[0] <= cyc) begin
        void'(b_times.pop_front());
        mst_bvalid = 1'b1;
        mst_bresp  = (b_hs_cnt == slverr_burst) ? 2'b10 : 2'b00;
        b_hs_cnt++;
      end else begin
        mst_bvalid = 1'b0;
        mst_bresp  = 2'b00;
      end
    end
  end

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference burst split: largest burst that fits both the AXI limit and the 4 KB page.
  task automatic push_model(input logic [31:0] addr, input int n);
    int rem, u, c;
    logic [31:0] a;
    a = addr;
    rem = n;
    while (rem > 0) begin
      u = (4096 - int'(a[11:0])) / 8;
      c = imin(imin(rem, 16), u);
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(4'(c - 1));
      exp_w_blen.push_back(c);
      a = a + 32'(c * 8);
      rem -= c;
    end
  endtask

  task automatic push_burst(input logic [31:0] addr, input int beats);
    exp_aw_addr.push_back(addr);
    exp_aw_len.push_back(4'(beats - 1));
    exp_w_blen.push_back(beats);
  endtask

  task automatic run_cfg(input logic [31:0] addr, input logic [15:0] len);
    int t;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_len   = len;
    t = 0;
    while (!cfg_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL cfg_timeout got cfg_ready=0 want 1");
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic drive_words(input int n, input int eof_idx, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        din_valid = 1'b0;
        @(negedge clk);
      end
      din_valid = 1'b1;
      din_data  = {$urandom, $urandom};
      din_eof   = (i == eof_idx);
      t = 0;
      while (!din_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (!din_ready) begin
        checks++;
        errors++;
        $display("FAIL din_timeout got din_ready=0 want 1 at word %0d", i);
        din_valid = 1'b0;
        return;
      end
      exp_wdata.push_back(din_data);
      @(negedge clk);
    end
    din_valid = 1'b0;
    din_eof   = 1'b0;
  endtask

  task automatic wait_done(input int exp_words, input bit exp_eof, input bit chk_closed, input string tag);
    int t;
    bit closed_bad;
    t = 0;
    closed_bad = 0;
    while (!done && t < 5000) begin
      if (din_ready) closed_bad = 1;
      @(negedge clk);
      t++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done_timeout got done=0 want 1", tag);
      return;
    end
    if (chk_closed) begin
      checks++;
      if (closed_bad) begin
        errors++;
        $display("FAIL %s_din_closed got din_ready=1 want 0 after eof", tag);
      end
    end
    checks++;
    if (xfer_words !== 16'(exp_words)) begin
      errors++;
      $display("FAIL %s_xfer_words got %0d want %0d", tag, xfer_words, exp_words);
    end
    checks++;
    if (xfer_eof !== exp_eof) begin
      errors++;
      $display("FAIL %s_xfer_eof got %b want %b", tag, xfer_eof, exp_eof);
    end
    checks++;
    if (b_hs_cnt !== aw_hs_cnt || b_times.size() != 0) begin
      errors++;
      $display("FAIL %s_done_before_b got b=%0d aw=%0d want equal", tag, b_hs_cnt, aw_hs_cnt);
    end
    checks++;
    if (exp_aw_addr.size() != 0 || exp_wdata.size() != 0 || exp_w_blen.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover got aw=%0d w=%0d want 0 0", tag, exp_aw_addr.size(), exp_wdata.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_pulse got done=%b cfg_ready=%b want 0 1", tag, done, cfg_ready);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (mst_awvalid !== 1'b0 || mst_wvalid !== 1'b0 || done !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_valids got aw=%b w=%b done=%b din_ready=%b want 0", tag,
               mst_awvalid, mst_wvalid, done, din_ready);
    end
    checks++;
    if (error !== 2'b00 || xfer_words !== 16'd0 || xfer_eof !== 1'b0) begin
      errors++;
      $display("FAIL %s_status got error=%b words=%0d eof=%b want 0", tag, error, xfer_words, xfer_eof);
    end
    checks++;
    if (cfg_ready !== 1'b1 || mst_bready !== 1'b1 || mst_awburst !== 2'b01 || mst_awsize !== 3'd3 ||
        mst_wstrb !== 8'hFF) begin
      errors++;
      $display("FAIL %s_consts got cfg_ready=%b bready=%b burst=%b size=%0d strb=%h want 1 1 01 3 ff",
               tag, cfg_ready, mst_bready, mst_awburst, mst_awsize, mst_wstrb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
  endtask

  task automatic test_eof_at_len();
    push_burst(32'h1000, 16);
    push_burst(32'h1080, 16);
    run_cfg(32'h1000, 16'd32);
    drive_words(32, 31, 1'b0);
    wait_done(32, 1'b1, 1'b0, "eof_at_len");
  endtask

  task automatic test_early_eof();
    push_burst(32'h2000, 6);
    run_cfg(32'h2000, 16'd100);
    drive_words(6, 5, 1'b0);
    din_valid = 1'b1;
    din_data  = 64'hDEAD_BEEF_0BAD_F00D;
    wait_done(6, 1'b1, 1'b1, "early_eof");
    checks++;
    if (din_ready !== 1'b0) begin
      errors++;
      $display("FAIL early_eof_idle_ready got %b want 0", din_ready);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_4k_split();
    push_burst(32'h0FE0, 4);
    push_burst(32'h1000, 12);
    run_cfg(32'h0FE0, 16'd16);
    drive_words(16, -1, 1'b0);
    wait_done(16, 1'b0, 1'b0, "split_4k");
  endtask

  task automatic test_back_to_back();
    aw_rand = 1;
    w_rand  = 1;
    b_delay = 20;
    push_model(32'h3000, 50);
    run_cfg(32'h3000, 16'd50);
    drive_words(50, -1, 1'b1);
    wait_done(50, 1'b0, 1'b0, "random_a");
    push_model(32'h5F40, 40);
    run_cfg(32'h5F40, 16'd60);
    drive_words(40, 39, 1'b1);
    wait_done(40, 1'b1, 1'b0, "random_b");
    aw_rand = 0;
    w_rand  = 0;
    b_delay = 1;
  endtask

  task automatic test_slverr();
    b_delay = 3;
    slverr_burst = b_hs_cnt + 1;
    push_model(32'h4000, 32);
    run_cfg(32'h4000, 16'd32);
    drive_words(32, -1, 1'b0);
    wait_done(32, 1'b0, 1'b0, "slverr");
    checks++;
    if (error !== 2'b10) begin
      errors++;
      $display("FAIL slverr_error got %b want 10", error);
    end
    slverr_burst = -1;
    push_model(32'h4100, 8);
    run_cfg(32'h4100, 16'd8);
    drive_words(8, -1, 1'b0);
    wait_done(8, 1'b0, 1'b0, "clean_after_err");
    checks++;
    if (error !== 2'b10) begin
      errors++;
      $display("FAIL sticky_error got %b want 10", error);
    end
    b_delay = 1;
  endtask

  task automatic test_zero_len();
    int d0, a0;
    d0 = done_cnt;
    a0 = aw_hs_cnt;
    run_cfg(32'h7000, 16'd0);
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != d0 || aw_hs_cnt != a0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_len got done=%0d aw=%0d cfg_ready=%b want done=%0d aw=%0d 1",
               done_cnt, aw_hs_cnt, cfg_ready, d0, a0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    aw_rand = 1;
    w_rand  = 1;
    b_delay = 5;
    push_model(32'h8000, 64);
    run_cfg(32'h8000, 16'd64);
    drive_words(40, -1, 1'b0);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    exp_aw_addr.delete();
    exp_aw_len.delete();
    exp_w_blen.delete();
    exp_wdata.delete();
    b_times.delete();
    aw_hs_cnt = 0;
    wl_cnt = 0;
    b_sched_cnt = 0;
    b_hs_cnt = 0;
    w_beat = 0;
    aw_rand = 0;
    w_rand = 0;
    b_delay = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset_mid");
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d pulses want %0d", done_cnt, d0);
    end
    push_burst(32'h9000, 4);
    run_cfg(32'h9000, 16'd4);
    drive_words(4, -1, 1'b0);
    wait_done(4, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_addr = '0;
    cfg_len = '0;
    din_valid = 1'b0;
    din_data = '0;
    din_eof = 1'b0;
    mst_awready = 1'b0;
    mst_wready = 1'b0;
    mst_bvalid = 1'b0;
    mst_bid = 4'd0;
    mst_bresp = 2'b00;
    test_reset();
    test_eof_at_len();
    test_early_eof();
    test_4k_split();
    test_zero_len();
    test_back_to_back();
    test_slverr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_writer_eof.md
Name: dma_writer_eof

Overview:
- Accepts a data stream with an end-of-frame flag and writes it to memory over an AXI3 write master (AW/W/B channels).
- A configuration stream supplies the start address and the maximum length of each transfer.
- A transfer ends at whichever comes first: the EOF word, or the configured length.
- An internal FIFO buffers incoming words. A write burst is issued only when the FIFO already holds all of that burst's data, so WVALID is never stalled mid-burst by the source.

Parameters:
- DataBits, 64: data width; a power of 2, at least 8.
- AddrBits, 32: address width.
- LengthBits, 16: width of the transfer length, in words.
- BurstSize, 16: maximum AXI burst length, at most 16.
- FifoDepth, 128: data FIFO depth; must be at least BurstSize.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- cfg_valid / cfg_ready  in/out  1  configuration handshake.
- cfg_addr  in  AddrBits  byte address; must be word aligned.
- cfg_len  in  LengthBits  maximum number of words to write.
- din_valid / din_ready  in/out  1  input stream handshake.
- din_data  in  DataBits  input word.
- din_eof  in  1  marks the last word of a frame.
- mst_awvalid / mst_awready  out/in  1  write address handshake.
- mst_awaddr  out  AddrBits  burst start address.
- mst_awlen  out  4  burst length minus 1.
- mst_awid  out  4  constant 0.
- mst_awsize  out  3  constant log2(DataBits/8).
- mst_awburst  out  2  constant 01 (INCR).
- mst_awlock  out  2  constant 00.
- mst_wvalid / mst_wready  out/in  1  write data handshake.
- mst_wdata  out  DataBits  write data.
- mst_wstrb  out  DataBits/8  all ones.
- mst_wlast  out  1  last beat of a burst.
- mst_wid  out  4  constant 0.
- mst_bvalid / mst_bready  in/out  1  write response handshake.
- mst_bid  in  4  ignored.
- mst_bresp  in  2  write response code.
- done  out  1  one-cycle pulse when the transfer is complete.
- xfer_words  out  LengthBits  words written by the last transfer; valid from the done pulse until the next done.
- xfer_eof  out  1  1 if the last transfer was ended by din_eof.
- error  out  2  last non-OKAY bresp seen; cleared only by rst.

Behaviour:
- Reset values: all valid outputs 0, done 0, error 0, xfer_words 0, xfer_eof 0, state Idle, FIFO empty, all counters 0. Reset mid-transfer abandons outstanding bursts with no done pulse.
- cfg_ready is 1 only in Idle.
- A cfg handshake with cfg_len = 0 is consumed with no AXI traffic and no done pulse.
- Otherwise the handshake latches addr and len, clears accepted/issued counters and the closed flag, and moves to Prep.
- Input side: din_ready = active AND !closed AND FIFO not full. "active" means any state other than Idle.
- Each accepted word increments accepted.
- closed is set the cycle a word with din_eof=1 is accepted, or when accepted reaches len. Words arriving in Idle or after closed wait; they are never dropped.
- unissued = accepted − issued.
- Prep (1 cycle): cand = min(unissued, BurstSize, until_4k), where until_4k = (4096 − addr[11:0]) / (DataBits/8). A burst never crosses a 4 KB boundary.
- Issue: when unissued ≥ min(BurstSize, until_4k), or closed with unissued > 0:
  - assert awvalid with awaddr = addr and awlen = cand − 1;
  - push cand into a 4-entry burst-length queue;
  - issued += cand; addr += cand·BytesPerWord;
  - outstanding += 1;
  - return to Prep.
- While awvalid=1 and awready=0, AW signals hold stable. No new AW is issued while the burst queue is full.
- Issue → WaitResp when closed and unissued = 0 and awvalid = 0.
- W side runs independently: it pops the queue head and streams that many FIFO words. wlast is asserted on the final beat. wvalid drops between bursts only if the queue is empty.
- B side: bready is tied to 1. Each B handshake decrements outstanding. A nonzero bresp updates error.
- WaitResp → Idle when outstanding = 0 and the W side is idle.
  - On that edge, done = 1 for one cycle, xfer_words = accepted, and xfer_eof = 1 if closure was by EOF.
  - EOF on exactly the len-th word gives xfer_eof = 1.
- Simultaneous B decrement and AW increment of outstanding net to no change.
- AW may complete before or after its W data; both orders are legal.

Test Plan:
- cfg addr=0x1000, len=32; 32 words, eof on word 31 → two AW (len=15 each) at 0x1000 and 0x1080; 32 W beats; done with xfer_words=32, xfer_eof=1.
- len=100; eof on word 5 → single AW with awlen=5; 6 beats; xfer_words=6, xfer_eof=1; din_ready=0 after the eof word until the next cfg.
- addr=0x0FE0 (64-bit), len=16, no eof → AW 0x0FE0 len=3, then AW 0x1000 len=11; xfer_eof=0.
- awready and wready toggling randomly, bvalid delayed 20 cycles → data and order intact; done only after the last B.
- bresp=SLVERR on the second burst → error=2'b10 and done still pulses; a later clean transfer leaves error=2'b10.
- rst asserted mid-burst, then a new cfg len=4 → all outputs at reset values; the new transfer completes with xfer_words=4.
